mac_result_drain: RTL and testbench
===================================

# mac_result_drain

Result-side drain for the parallel MAC array: captures the N accumulated lane results the array presents on its lane-valid strobes and streams them out one element per cycle over a ready/valid handshake, lane 0 first. Two-bank ping-pong buffer, so one frame can be captured while the previous frame is still draining. Sits directly behind the MAC array and feeds the matrix result writer.

## Interface

- N, 5, number of MAC lanes (elements per frame)
- WIDTH, 16, operand width of the MAC array
- M_WIDTH, 2*WIDTH+N-1, width of one lane result
- IDX_W, 3, width of element index; must satisfy 2**IDX_W >= N

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- C_in  in  N*M_WIDTH  lane results; lane i at bits [M_WIDTH*(i+1)-1 : M_WIDTH*i]
- valid_in  in  N  per-lane result valid from the MAC array
- out_data  out  M_WIDTH  current element
- out_idx  out  IDX_W  lane index of out_data, 0..N-1
- out_last  out  1  high with element N-1
- out_valid  out  1  out_data/out_idx/out_last valid
- out_ready  in  1  downstream accepts when high with out_valid
- busy  out  1  at least one bank full
- overflow  out  1  sticky: a frame was dropped
- mismatch  out  1  sticky: valid_in partially set

## Operation

- Capture event: cycle where &valid_in = 1. Whole C_in written into the write bank; bank marked full; write pointer toggles.
- Partial valid (valid_in != 0 and != all-ones): no capture, mismatch set. Sticky until reset.
- Bank eligible for capture if empty, or being released on the same edge (last element handshake this cycle).
- No eligible bank at capture: frame dropped, overflow set, banks untouched. Sticky until reset.
- Read FSM, states IDLE and SEND:
  - IDLE: read bank full -> SEND, idx=0.
  - SEND: out_valid=1, out_data = read bank lane idx, out_idx=idx, out_last=(idx==N-1).
  - Handshake (out_valid & out_ready): idx<N-1 -> idx+1; idx==N-1 -> read bank cleared, read pointer toggles; other bank full -> stay SEND with idx=0 (no bubble), else IDLE.
  - No handshake: all outputs held stable.
- Outputs registered; out_data is the registered selected lane.
- busy = either bank full.
- Reset: out_valid=0, out_data=0, out_idx=0, out_last=0, overflow=0, mismatch=0, busy=0, both banks empty, both pointers bank 0, FSM IDLE. Reset mid-drain discards both banks; no further elements emitted.

## Timing

- Capture at edge ending cycle k (&valid_in in cycle k); with drain idle, out_valid=1 and element 0 present in cycle k+1.
- Throughput with out_ready held high: one element per cycle; N cycles per frame; consecutive buffered frames stream with no idle cycle.
- Frame presented by the MAC array every N cycles is sustained indefinitely with out_ready=1.
- Capture and release on same edge: new frame goes into releasing bank; no overflow.
- out_ready may change any cycle; out_valid never drops without a handshake except on reset.

## Test plan

- Single frame, N=5, lanes = 10,20,30,40,50, out_ready=1 -> cycles k+1..k+5 emit 10..50, idx 0..4, out_last only on 50, then out_valid=0, busy=0.
- Backpressure: same frame, out_ready toggled 1,0,0,1,... -> every element emitted exactly once, data/idx held during stalls, order preserved.
- Two frames back-to-back (captures 1 cycle apart), out_ready=1 -> 10 elements contiguous, no gap between out_last of frame 1 and idx 0 of frame 2, overflow=0.
- Three captures while out_ready=0 -> frames 1,2 retained, third dropped, overflow=1; release ready -> exactly frames 1 then 2 drained.
- valid_in=5'b00111 for one cycle -> no output, mismatch=1, overflow=0; following full-valid frame drained normally.
- Reset asserted (rst_n=0) at element idx 2 with second frame buffered -> next cycle all outputs 0, busy=0, flags 0; no residual elements after rst_n=1.

Source files
------------

// File: rtl/mac_result_drain.sv
// mac_result_drain: ping-pong capture of MAC lane results and
// in-order per-element drain over a ready/valid handshake.
module mac_result_drain #(
  parameter int N       = 5,
  parameter int WIDTH   = 16,
  parameter int M_WIDTH = 2*WIDTH+N-1,
  parameter int IDX_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*M_WIDTH-1:0] C_in,
  input  logic [N-1:0]         valid_in,
  output logic [M_WIDTH-1:0]   out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 overflow,
  output logic                 mismatch
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N-1);

  logic [N-1:0][M_WIDTH-1:0] lanes;
  logic [N-1:0][M_WIDTH-1:0] bank [2];

  state_t state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [1:0] full, full_eff, full_n;
  logic wr_ptr, wr_ptr_n;
  logic rd_ptr, rd_ptr_n;
  logic hs, rel, cap_req, do_cap, drop, part;
  logic out_valid_n, out_last_n;
  logic [M_WIDTH-1:0] sel_data, out_data_n;

  assign lanes = C_in;
  assign busy  = |full;

  // bank bookkeeping: release, capture eligibility, pointer moves
  always_comb begin
    hs       = out_valid & out_ready;
    rel      = hs & (idx == LAST);
    full_eff = full;
    if (rel) full_eff[rd_ptr] = 1'b0;
    cap_req  = &valid_in;
    do_cap   = cap_req & ~full_eff[wr_ptr];
    drop     = cap_req & full_eff[wr_ptr];
    part     = (|valid_in) & ~cap_req;
    full_n   = full_eff;
    if (do_cap) full_n[wr_ptr] = 1'b1;
    wr_ptr_n = wr_ptr ^ do_cap;
    rd_ptr_n = rd_ptr ^ rel;
  end

  // read FSM next state and element index
  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      IDLE: begin
        if (full_n[rd_ptr_n]) begin
          state_n = SEND;
          idx_n   = '0;
        end
      end
      SEND: begin
        if (rel) begin
          idx_n   = '0;
          state_n = full_n[rd_ptr_n] ? SEND : IDLE;
        end else if (hs) begin
          idx_n = idx + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  // next output values; a frame landing this edge bypasses the bank
  always_comb begin
    if (do_cap && (wr_ptr == rd_ptr_n))
      sel_data = lanes[idx_n];
    else
      sel_data = bank[rd_ptr_n][idx_n];
    out_valid_n = (state_n == SEND);
    out_last_n  = out_valid_n && (idx_n == LAST);
    out_data_n  = out_valid_n ? sel_data : out_data;
  end

  // state, pointers, flags and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      full      <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      overflow  <= 1'b0;
      mismatch  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      full      <= full_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      overflow  <= overflow | drop;
      mismatch  <= mismatch | part;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      out_data  <= out_data_n;
    end
  end

  assign out_idx = idx;

  // bank storage needs no reset; emptiness lives in full
  always_ff @(posedge clk) begin
    if (do_cap) bank[wr_ptr] <= lanes;
  end

endmodule

// File: tb/tb_mac_result_drain.sv
// tb_mac_result_drain: queue-level reference model checked every
// cycle, plus directed literal checks and random traffic.
module tb_mac_result_drain;

  localparam int N  = 5;
  localparam int W  = 16;
  localparam int MW = 2*W+N-1;
  localparam int IW = 3;

  typedef logic [N*MW-1:0] frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  frame_t c_in = '0;
  logic [N-1:0] valid_in = '0;
  logic out_ready = 1'b0;
  logic [MW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic out_last, out_valid, busy, overflow, mismatch;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  frame_t q[$];
  int pos = 0;
  bit m_ovf = 1'b0;
  bit m_mis = 1'b0;

  mac_result_drain #(.N(N), .WIDTH(W), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .C_in(c_in), .valid_in(valid_in),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .overflow(overflow), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [MW-1:0] elem(frame_t f, int p);
    frame_t t;
    t = f >> (p*MW);
    return t[MW-1:0];
  endfunction

  function automatic frame_t mk(int b, int s);
    frame_t f = '0;
    for (int i = 0; i < N; i++)
      f[i*MW +: MW] = MW'(b + s*i);
    return f;
  endfunction

  function automatic frame_t rnd_frame();
    frame_t f;
    for (int i = 0; i < N; i++)
      f[i*MW +: MW] = {$urandom, $urandom};
    return f;
  endfunction

  // reference: FIFO of at most two frames, head drains element by element
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      pos = 0;
      m_ovf = 1'b0;
      m_mis = 1'b0;
    end else begin
      if (q.size() > 0 && out_ready) begin
        if (pos == N-1) begin
          void'(q.pop_front());
          pos = 0;
        end else begin
          pos++;
        end
      end
      if (&valid_in) begin
        if (q.size() < 2) q.push_back(c_in);
        else m_ovf = 1'b1;
      end else if (valid_in != '0) begin
        m_mis = 1'b1;
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 64'(out_valid), 64'(q.size() > 0));
      chk("busy", 64'(busy), 64'(q.size() > 0));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("mismatch", 64'(mismatch), 64'(m_mis));
      if (q.size() > 0) begin
        chk("data", 64'(out_data), 64'(elem(q[0], pos)));
        chk("idx", 64'(out_idx), 64'(pos));
        chk("last", 64'(out_last), 64'(pos == N-1));
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cap(frame_t f);
    c_in = f;
    valid_in = '1;
    tick();
    valid_in = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_idx", 64'(out_idx), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flags", 64'({overflow, mismatch}), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int pat[4] = '{1, 0, 0, 1};
    do_reset();
    chk_en = 1'b1;

    // single frame 10..50
    out_ready = 1'b1;
    cap(mk(10, 10));
    chk("s_first_data", 64'(out_data), 64'd10);
    chk("s_first_idx", 64'(out_idx), 64'd0);
    chk("s_first_valid", 64'(out_valid), 64'd1);
    tick(4);
    chk("s_last_data", 64'(out_data), 64'd50);
    chk("s_last_flag", 64'(out_last), 64'd1);
    tick();
    chk("s_done_valid", 64'(out_valid), 64'd0);
    chk("s_done_busy", 64'(busy), 64'd0);

    // partial valid
    c_in = mk(1, 1);
    valid_in = 5'b00111;
    tick();
    valid_in = '0;
    chk("p_mismatch", 64'(mismatch), 64'd1);
    chk("p_overflow", 64'(overflow), 64'd0);
    chk("p_valid", 64'(out_valid), 64'd0);
    cap(mk(100, 1));
    tick(6);

    // backpressure
    do_reset();
    cap(mk(10, 10));
    for (int i = 0; i < 16; i++) begin
      out_ready = pat[i % 4][0];
      tick();
    end
    out_ready = 1'b1;

    // back-to-back frames
    cap(mk(200, 3));
    cap(mk(300, 7));
    tick(12);
    chk("b2b_overflow", 64'(overflow), 64'd0);

    // three captures under stall
    out_ready = 1'b0;
    cap(mk(400, 1));
    cap(mk(500, 1));
    cap(mk(600, 1));
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_head", 64'(out_data), 64'd400);
    out_ready = 1'b1;
    tick(5);
    chk("ovf_second", 64'(out_data), 64'd500);
    tick(6);
    chk("ovf_drained", 64'(out_valid), 64'd0);

    // sustained: one frame every N cycles
    do_reset();
    for (int f = 0; f < 6; f++) begin
      cap(rnd_frame());
      tick(N-1);
    end
    tick(N+1);
    chk("sus_overflow", 64'(overflow), 64'd0);

    // reset mid-drain with a second frame buffered
    cap(mk(10, 10));
    cap(mk(60, 10));
    tick();
    chk("rm_idx", 64'(out_idx), 64'd2);
    rst_n = 1'b0;
    tick();
    chk("rm_valid", 64'(out_valid), 64'd0);
    chk("rm_data", 64'(out_data), 64'd0);
    chk("rm_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick(12);
    chk("rm_quiet", 64'(out_valid), 64'd0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int r = $urandom_range(0, 39);
      c_in = rnd_frame();
      if (r < 9) valid_in = '1;
      else if (r == 9) valid_in = N'($urandom_range(1, (1 << N) - 2));
      else valid_in = '0;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    valid_in = '0;
    out_ready = 1'b1;
    tick(15);
    chk("rnd_drained", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
